// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch sequencer: fetches over a req/ack bus,
// holds the instruction for decode and applies next-PC / exception updates.
//
// state | meaning
// IDLE  | held in reset, leaves on the first clock after release
// FETCH | imem_req high at pc, waiting for ack or timeout
// EXEC  | instruction held for decode, waiting for a next-PC command
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC      = 32'h0000_3000,
    parameter logic [31:0] EXC_VECTOR    = 32'h0000_4180,
    parameter int          FETCH_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  npc_op,
    input  logic        npc_valid,
    input  logic        stall,
    input  logic [15:0] imm16,
    input  logic [25:0] jidx,
    input  logic [31:0] jr_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] epc,
    output logic        exc,
    output logic        bus_err
);

    localparam int CW = $clog2(FETCH_TIMEOUT + 1);
    localparam logic [CW-1:0] TO_TC = CW'(FETCH_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [CW-1:0] to_cnt, to_cnt_nx;
    logic [31:0]   pc_nx, epc_nx, instr_nx;
    logic          exc_nx, bus_err_nx, take_exc;
    logic [31:0]   br_off;

    assign pc_plus4    = pc + 32'd4;
    assign br_off      = {{14{imm16[15]}}, imm16, 2'b00};
    assign imem_req    = (state == FETCH);
    assign imem_addr   = pc;
    assign instr_valid = (state == EXEC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        pc_nx      = pc;
        epc_nx     = epc;
        instr_nx   = instr;
        to_cnt_nx  = to_cnt;
        exc_nx     = 1'b0;
        bus_err_nx = 1'b0;
        take_exc   = 1'b0;
        case (state)
            IDLE: state_nx = FETCH;
            FETCH: begin
                // ack beats a timeout landing in the same cycle
                if (imem_ack) begin
                    instr_nx  = imem_rdata;
                    to_cnt_nx = '0;
                    state_nx  = EXEC;
                end else if (to_cnt == TO_TC) begin
                    bus_err_nx = 1'b1;
                    take_exc   = 1'b1;
                    to_cnt_nx  = '0;
                end else begin
                    to_cnt_nx = to_cnt + CW'(1);
                end
            end
            EXEC: begin
                if (npc_valid && !stall) begin
                    state_nx = FETCH;
                    case (npc_op)
                        3'd0: pc_nx = pc_plus4;
                        3'd1: pc_nx = pc_plus4 + br_off;
                        3'd2: pc_nx = {pc_plus4[31:28], jidx, 2'b00};
                        3'd3: begin
                            if (jr_target[1:0] == 2'b00) pc_nx = jr_target;
                            else                         take_exc = 1'b1;
                        end
                        default: take_exc = 1'b1;
                    endcase
                end
            end
            default: state_nx = IDLE;
        endcase
        if (take_exc) begin
            epc_nx = pc;
            pc_nx  = EXC_VECTOR;
            exc_nx = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc      <= RESET_PC;
            epc     <= '0;
            instr   <= '0;
            to_cnt  <= '0;
            exc     <= 1'b0;
            bus_err <= 1'b0;
        end else begin
            pc      <= pc_nx;
            epc     <= epc_nx;
            instr   <= instr_nx;
            to_cnt  <= to_cnt_nx;
            exc     <= exc_nx;
            bus_err <= bus_err_nx;
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed cases plus randomized fetch/exec traffic
// checked against a transaction-level model of the PC rules.
module tb_pc_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_3000;
    localparam logic [31:0] EXC_V  = 32'h0000_4180;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  npc_op;
    logic        npc_valid, stall;
    logic [15:0] imm16;
    logic [25:0] jidx;
    logic [31:0] jr_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc, pc_plus4, epc;
    logic        exc, bus_err;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] m_pc, m_epc, m_instr;
    logic        exp_exc, exp_berr;

    pc_fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .npc_op(npc_op), .npc_valid(npc_valid),
        .stall(stall), .imm16(imm16), .jidx(jidx), .jr_target(jr_target),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .instr(instr), .instr_valid(instr_valid),
        .pc(pc), .pc_plus4(pc_plus4), .epc(epc), .exc(exc), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, expv, $time);
        end
    endtask

    // {exception, next pc} from the architectural next-PC rules
    function automatic logic [32:0] model_next(input logic [2:0] op, input logic [31:0] cur,
                                               input logic [15:0] imm, input logic [25:0] ji,
                                               input logic [31:0] jr);
        logic [31:0] seq;
        int off;
        seq = cur + 32'd4;
        off = int'($signed(imm)) * 4;
        case (op)
            3'd0: return {1'b0, seq};
            3'd1: return {1'b0, seq + 32'(off)};
            3'd2: return {1'b0, (seq & 32'hF000_0000) | (32'(ji) * 32'd4)};
            3'd3: return (jr % 4 != 0) ? {1'b1, EXC_V} : {1'b0, jr};
            default: return {1'b1, EXC_V};
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        chk("exc_pulse", 32'(exc), 32'(exp_exc));
        chk("bus_err_pulse", 32'(bus_err), 32'(exp_berr));
        exp_exc  = 1'b0;
        exp_berr = 1'b0;
    endtask

    task automatic fetch(input int waits);
        for (int i = 0; i <= waits; i++) begin
            chk("req_fetch", 32'(imem_req), 32'd1);
            chk("addr_fetch", imem_addr, m_pc);
            chk("ivalid_fetch", 32'(instr_valid), 32'd0);
            imem_rdata = $urandom;
            if (i == waits) begin
                imem_ack = 1'b1;
                m_instr  = imem_rdata;
            end else begin
                imem_ack = 1'b0;
            end
            step();
        end
        imem_ack = 1'b0;
    endtask

    task automatic timeout_fetch();
        for (int i = 0; i < 16; i++) begin
            chk("req_to", 32'(imem_req), 32'd1);
            chk("addr_to", imem_addr, m_pc);
            imem_ack   = 1'b0;
            imem_rdata = $urandom;
            if (i == 15) begin
                exp_exc  = 1'b1;
                exp_berr = 1'b1;
                m_epc    = m_pc;
                m_pc     = EXC_V;
            end
            step();
        end
        chk("pc_to", pc, m_pc);
        chk("epc_to", epc, m_epc);
    endtask

    task automatic exec(input logic [2:0] op, input logic [15:0] imm, input logic [25:0] ji,
                        input logic [31:0] jr, input int nstall, input int nidle);
        logic [32:0] nx;
        chk("ivalid_exec", 32'(instr_valid), 32'd1);
        chk("instr_exec", instr, m_instr);
        chk("pc_exec", pc, m_pc);
        chk("pc_plus4", pc_plus4, m_pc + 32'd4);
        chk("req_exec", 32'(imem_req), 32'd0);
        for (int i = 0; i < nidle; i++) begin
            npc_valid  = 1'b0;
            stall      = 1'($urandom);
            npc_op     = 3'($urandom);
            imm16      = 16'($urandom);
            jidx       = 26'($urandom);
            jr_target  = $urandom;
            imem_ack   = 1'($urandom);
            imem_rdata = $urandom;
            step();
            chk("pc_idle", pc, m_pc);
            chk("instr_idle", instr, m_instr);
        end
        npc_op = op; imm16 = imm; jidx = ji; jr_target = jr;
        for (int i = 0; i < nstall; i++) begin
            npc_valid  = 1'b1;
            stall      = 1'b1;
            imem_ack   = 1'($urandom);
            imem_rdata = $urandom;
            step();
            chk("pc_stall", pc, m_pc);
            chk("ivalid_stall", 32'(instr_valid), 32'd1);
        end
        npc_valid = 1'b1;
        stall     = 1'b0;
        imem_ack  = 1'b0;
        nx = model_next(op, m_pc, imm, ji, jr);
        if (nx[32]) begin
            m_epc   = m_pc;
            exp_exc = 1'b1;
        end
        m_pc = nx[31:0];
        step();
        npc_valid = 1'b0;
        chk("pc_next", pc, m_pc);
        chk("epc", epc, m_epc);
        chk("ivalid_drop", 32'(instr_valid), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_pc"}, pc, RST_PC);
        chk({tag, "_epc"}, epc, 32'd0);
        chk({tag, "_instr"}, instr, 32'd0);
        chk({tag, "_ivalid"}, 32'(instr_valid), 32'd0);
        chk({tag, "_req"}, 32'(imem_req), 32'd0);
        chk({tag, "_exc"}, 32'(exc), 32'd0);
        chk({tag, "_berr"}, 32'(bus_err), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] jr;
        logic [2:0]  op;
        int          w;
        rst_n = 1'b0; npc_op = '0; npc_valid = 1'b0; stall = 1'b0;
        imm16 = '0; jidx = '0; jr_target = '0; imem_ack = 1'b0; imem_rdata = '0;
        exp_exc = 1'b0; exp_berr = 1'b0;
        m_pc = RST_PC; m_epc = '0; m_instr = '0;
        repeat (2) @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        step();

        // sequential fetch from reset
        chk("seq_a0", imem_addr, 32'h3000);
        fetch(0); exec(3'd0, 16'h0, 26'h0, 32'h0, 0, 0);
        chk("seq_a1", imem_addr, 32'h3004);
        fetch(0); exec(3'd0, 16'h0, 26'h0, 32'h0, 0, 0);
        chk("seq_a2", imem_addr, 32'h3008);
        fetch(0); exec(3'd4, 16'h0, 26'h0, 32'h0, 3, 0);
        chk("except_pc", pc, 32'h4180);
        chk("except_epc", epc, 32'h3008);

        fetch(0); exec(3'd3, 16'h0, 26'h0, 32'h3010, 0, 0);
        fetch(0); exec(3'd1, 16'hFFFE, 26'h0, 32'h0, 0, 0);
        chk("branch_back", pc, 32'h300C);
        fetch(1); exec(3'd3, 16'h0, 26'h0, 32'h3010, 0, 2);
        fetch(0); exec(3'd1, 16'h0003, 26'h0, 32'h0, 0, 0);
        chk("branch_fwd", pc, 32'h3020);
        fetch(0); exec(3'd3, 16'h0, 26'h0, 32'h3000, 0, 0);
        fetch(0); exec(3'd2, 16'h0, 26'h0000C10, 32'h0, 0, 0);
        chk("jump", pc, 32'h3040);
        fetch(2); exec(3'd3, 16'h0, 26'h0, 32'h3100, 0, 0);
        chk("jr", pc, 32'h3100);
        fetch(0); exec(3'd3, 16'h0, 26'h0, 32'h3102, 0, 0);
        chk("jr_misaligned_pc", pc, 32'h4180);
        chk("jr_misaligned_epc", epc, 32'h3100);

        // fetch timeout, then ack landing on the terminal cycle
        timeout_fetch();
        fetch(15);
        exec(3'd0, 16'h0, 26'h0, 32'h0, 0, 0);

        // async reset in the middle of a wait-stated fetch
        for (int i = 0; i < 3; i++) begin
            imem_ack = 1'b0;
            step();
        end
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        m_pc = RST_PC; m_epc = '0; m_instr = '0;
        step();
        chk("midrst_first_addr", imem_addr, 32'h3000);
        fetch(0);
        exec(3'd0, 16'h0, 26'h0, 32'h0, 0, 0);

        for (int it = 0; it < 200; it++) begin
            w = ($urandom_range(0, 9) == 0) ? 15 : int'($urandom_range(0, 3));
            if ($urandom_range(0, 14) == 0) timeout_fetch();
            fetch(w);
            jr = $urandom;
            if ($urandom_range(0, 3) != 0) jr[1:0] = 2'b00;
            op = 3'($urandom);
            exec(op, 16'($urandom), 26'($urandom), jr,
                 int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
